// File: rtl/ecc_secded_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : ecc_secded_pipe_if
// Brief    : Read-beat input and corrected-beat output handshake bundle
//            for the pipelined SECDED checker.
// Revision : 1.0  initial release
// ============================================================================
interface ecc_secded_pipe_if #(
    parameter int DATA_WIDTH   = 70,
    parameter int PARITY_WIDTH = 8,
    parameter int ADDR_WIDTH   = 10
);
    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_WIDTH-1:0]   in_data;
    logic [PARITY_WIDTH-1:0] in_parity;
    logic [ADDR_WIDTH-1:0]   in_addr;
    logic                    in_bypass;

    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_WIDTH-1:0]   out_data;
    logic                    out_sbit_err;
    logic                    out_dbit_err;
    logic [PARITY_WIDTH-1:0] out_syndrome;

    modport master (
        output in_valid, in_data, in_parity, in_addr, in_bypass, out_ready,
        input  in_ready, out_valid, out_data, out_sbit_err, out_dbit_err, out_syndrome
    );

    modport slave (
        input  in_valid, in_data, in_parity, in_addr, in_bypass, out_ready,
        output in_ready, out_valid, out_data, out_sbit_err, out_dbit_err, out_syndrome
    );
endinterface
`default_nettype wire

// File: rtl/ecc_secded_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ecc_secded_pipe
// Brief    : Two-stage Hsiao SECDED checker/corrector with valid/ready
//            flow control, saturating error counters and a first-error log.
// Revision : 1.0  initial release
// ============================================================================
module ecc_secded_pipe #(
    parameter int DATA_WIDTH   = 70,
    parameter int PARITY_WIDTH = 8,
    parameter int ADDR_WIDTH   = 10,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH-1:0]   enc_data,
    output logic [PARITY_WIDTH-1:0] enc_parity,
    ecc_secded_pipe_if.slave        bus,
    input  logic                    clr_stats,
    output logic [CNT_WIDTH-1:0]    sbit_cnt,
    output logic [CNT_WIDTH-1:0]    dbit_cnt,
    output logic                    log_valid,
    output logic                    log_dbit,
    output logic [ADDR_WIDTH-1:0]   log_addr,
    output logic [PARITY_WIDTH-1:0] log_syndrome
);

    // Data column i: i-th non-power-of-two integer >= 3 in the low bits, MSB forces odd weight.
    function automatic logic [DATA_WIDTH*PARITY_WIDTH-1:0] build_cols();
        logic [DATA_WIDTH*PARITY_WIDTH-1:0] cols;
        logic [PARITY_WIDTH-2:0]            low;
        int                                 v;
        int                                 n;
        cols = '0;
        v    = 3;
        n    = 0;
        while (n < DATA_WIDTH) begin
            if ((v & (v - 1)) != 0) begin
                low = v[PARITY_WIDTH-2:0];
                cols[n*PARITY_WIDTH +: PARITY_WIDTH] = {~^low, low};
                n++;
            end
            v++;
        end
        return cols;
    endfunction

    localparam logic [DATA_WIDTH*PARITY_WIDTH-1:0] H_COLS = build_cols();

    function automatic logic [PARITY_WIDTH-1:0] encode(input logic [DATA_WIDTH-1:0] d);
        logic [PARITY_WIDTH-1:0] p;
        p = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (d[i]) p = p ^ H_COLS[i*PARITY_WIDTH +: PARITY_WIDTH];
        end
        return p;
    endfunction

    logic                    s1_valid_q, s1_valid_d;
    logic [DATA_WIDTH-1:0]   s1_data_q, s1_data_d;
    logic [ADDR_WIDTH-1:0]   s1_addr_q, s1_addr_d;
    logic                    s1_bypass_q, s1_bypass_d;
    logic [PARITY_WIDTH-1:0] s1_syndrome_q, s1_syndrome_d;

    logic                    s2_valid_q, s2_valid_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic                    out_sbit_q, out_sbit_d;
    logic                    out_dbit_q, out_dbit_d;
    logic [PARITY_WIDTH-1:0] out_syndrome_q, out_syndrome_d;
    logic [ADDR_WIDTH-1:0]   s2_addr_q, s2_addr_d;

    logic [CNT_WIDTH-1:0]    sbit_cnt_q, sbit_cnt_d;
    logic [CNT_WIDTH-1:0]    dbit_cnt_q, dbit_cnt_d;
    logic                    log_valid_q, log_valid_d;
    logic                    log_dbit_q, log_dbit_d;
    logic [ADDR_WIDTH-1:0]   log_addr_q, log_addr_d;
    logic [PARITY_WIDTH-1:0] log_syndrome_q, log_syndrome_d;

    logic                    w_s1_en;
    logic                    w_s2_en;
    logic                    w_out_hs;
    logic [PARITY_WIDTH-1:0] w_in_syn;
    logic [PARITY_WIDTH-1:0] w_syn;
    logic [DATA_WIDTH-1:0]   w_flip;
    logic                    w_chk_err;
    logic                    w_sbit;
    logic                    w_dbit;

    always_comb begin
        enc_parity = encode(enc_data);
        w_in_syn   = encode(bus.in_data) ^ bus.in_parity;
        w_s2_en    = !s2_valid_q || bus.out_ready;
        w_s1_en    = !s1_valid_q || w_s2_en;
        w_out_hs   = s2_valid_q && bus.out_ready;

        // A bypassed beat decodes as clean, which also suppresses flags and correction.
        w_syn  = s1_bypass_q ? '0 : s1_syndrome_q;
        w_flip = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            w_flip[i] = (w_syn == H_COLS[i*PARITY_WIDTH +: PARITY_WIDTH]);
        end
        w_chk_err = (w_syn != '0) && ((w_syn & (w_syn - PARITY_WIDTH'(1))) == '0);
        w_sbit    = (|w_flip) || w_chk_err;
        w_dbit    = (w_syn != '0) && !w_sbit;

        s1_valid_d     = s1_valid_q;
        s1_data_d      = s1_data_q;
        s1_addr_d      = s1_addr_q;
        s1_bypass_d    = s1_bypass_q;
        s1_syndrome_d  = s1_syndrome_q;
        s2_valid_d     = s2_valid_q;
        out_data_d     = out_data_q;
        out_sbit_d     = out_sbit_q;
        out_dbit_d     = out_dbit_q;
        out_syndrome_d = out_syndrome_q;
        s2_addr_d      = s2_addr_q;
        sbit_cnt_d     = sbit_cnt_q;
        dbit_cnt_d     = dbit_cnt_q;
        log_valid_d    = log_valid_q;
        log_dbit_d     = log_dbit_q;
        log_addr_d     = log_addr_q;
        log_syndrome_d = log_syndrome_q;

        if (w_s1_en) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_data_d     = bus.in_data;
                s1_addr_d     = bus.in_addr;
                s1_bypass_d   = bus.in_bypass;
                s1_syndrome_d = w_in_syn;
            end
        end

        if (w_s2_en) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d     = s1_data_q ^ w_flip;
                out_sbit_d     = w_sbit;
                out_dbit_d     = w_dbit;
                out_syndrome_d = w_syn;
                s2_addr_d      = s1_addr_q;
            end
        end

        if (clr_stats) begin
            sbit_cnt_d     = '0;
            dbit_cnt_d     = '0;
            log_valid_d    = 1'b0;
            log_dbit_d     = 1'b0;
            log_addr_d     = '0;
            log_syndrome_d = '0;
        end else if (w_out_hs) begin
            if (out_sbit_q && (sbit_cnt_q != '1)) sbit_cnt_d = sbit_cnt_q + CNT_WIDTH'(1);
            if (out_dbit_q && (dbit_cnt_q != '1)) dbit_cnt_d = dbit_cnt_q + CNT_WIDTH'(1);
            // First flagged beat wins, except an uncorrectable beat displaces a correctable entry.
            if (((out_sbit_q || out_dbit_q) && !log_valid_q) ||
                (out_dbit_q && log_valid_q && !log_dbit_q)) begin
                log_valid_d    = 1'b1;
                log_dbit_d     = out_dbit_q;
                log_addr_d     = s2_addr_q;
                log_syndrome_d = out_syndrome_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q     <= 1'b0;
            s1_data_q      <= '0;
            s1_addr_q      <= '0;
            s1_bypass_q    <= 1'b0;
            s1_syndrome_q  <= '0;
            s2_valid_q     <= 1'b0;
            out_data_q     <= '0;
            out_sbit_q     <= 1'b0;
            out_dbit_q     <= 1'b0;
            out_syndrome_q <= '0;
            s2_addr_q      <= '0;
            sbit_cnt_q     <= '0;
            dbit_cnt_q     <= '0;
            log_valid_q    <= 1'b0;
            log_dbit_q     <= 1'b0;
            log_addr_q     <= '0;
            log_syndrome_q <= '0;
        end else begin
            s1_valid_q     <= s1_valid_d;
            s1_data_q      <= s1_data_d;
            s1_addr_q      <= s1_addr_d;
            s1_bypass_q    <= s1_bypass_d;
            s1_syndrome_q  <= s1_syndrome_d;
            s2_valid_q     <= s2_valid_d;
            out_data_q     <= out_data_d;
            out_sbit_q     <= out_sbit_d;
            out_dbit_q     <= out_dbit_d;
            out_syndrome_q <= out_syndrome_d;
            s2_addr_q      <= s2_addr_d;
            sbit_cnt_q     <= sbit_cnt_d;
            dbit_cnt_q     <= dbit_cnt_d;
            log_valid_q    <= log_valid_d;
            log_dbit_q     <= log_dbit_d;
            log_addr_q     <= log_addr_d;
            log_syndrome_q <= log_syndrome_d;
        end
    end

    assign bus.in_ready     = rst_n && w_s1_en;
    assign bus.out_valid    = s2_valid_q;
    assign bus.out_data     = out_data_q;
    assign bus.out_sbit_err = out_sbit_q;
    assign bus.out_dbit_err = out_dbit_q;
    assign bus.out_syndrome = out_syndrome_q;
    assign sbit_cnt         = sbit_cnt_q;
    assign dbit_cnt         = dbit_cnt_q;
    assign log_valid        = log_valid_q;
    assign log_dbit         = log_dbit_q;
    assign log_addr         = log_addr_q;
    assign log_syndrome     = log_syndrome_q;

endmodule
`default_nettype wire

// File: tb/tb_ecc_secded_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_ecc_secded_pipe
// Brief    : Scoreboard bench for ecc_secded_pipe (saturation at CNT_WIDTH=2).
// Revision : 1.0  initial release
// ============================================================================
module tb_ecc_secded_pipe;
    localparam int DW = 70;
    localparam int PW = 8;
    localparam int AW = 10;
    localparam int CW = 2;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sbit;
        logic          dbit;
        logic [PW-1:0] syn;
        logic [AW-1:0] addr;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] enc_data = '0;
    logic [PW-1:0] enc_parity;
    logic          clr_stats = 1'b0;
    logic [CW-1:0] sbit_cnt;
    logic [CW-1:0] dbit_cnt;
    logic          log_valid;
    logic          log_dbit;
    logic [AW-1:0] log_addr;
    logic [PW-1:0] log_syndrome;

    ecc_secded_pipe_if #(.DATA_WIDTH(DW), .PARITY_WIDTH(PW), .ADDR_WIDTH(AW)) bus ();

    ecc_secded_pipe #(.DATA_WIDTH(DW), .PARITY_WIDTH(PW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enc_data     (enc_data),
        .enc_parity   (enc_parity),
        .bus          (bus),
        .clr_stats    (clr_stats),
        .sbit_cnt     (sbit_cnt),
        .dbit_cnt     (dbit_cnt),
        .log_valid    (log_valid),
        .log_dbit     (log_dbit),
        .log_addr     (log_addr),
        .log_syndrome (log_syndrome)
    );

    always #5 clk = ~clk;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [PW-1:0] col [DW];
    exp_t          q [$];
    logic          saw_stall = 1'b0;
    logic          stream_done = 1'b0;

    int            m_sc = 0;
    int            m_dc = 0;
    logic          m_lv = 1'b0;
    logic          m_ld = 1'b0;
    logic [AW-1:0] m_la = '0;
    logic [PW-1:0] m_ls = '0;
    logic          prev_hold = 1'b0;
    exp_t          prev_out;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic void init_cols();
        int n = 0;
        for (int v = 3; n < DW; v++) begin
            if ($countones(v) != 1) begin
                logic [PW-1:0] c;
                c         = PW'(v);
                c[PW-1]   = ($countones(v) % 2 == 0);
                col[n]    = c;
                n++;
            end
        end
    endfunction

    function automatic logic [PW-1:0] tb_enc(input logic [DW-1:0] d);
        logic [PW-1:0] p = '0;
        for (int i = 0; i < DW; i++) if (d[i]) p = p ^ col[i];
        return p;
    endfunction

    function automatic exp_t model(input logic [DW-1:0] d, input logic [PW-1:0] p,
                                   input logic [AW-1:0] a, input logic byp);
        exp_t          e;
        logic [PW-1:0] s;
        int            hit;
        e.data = d; e.sbit = 1'b0; e.dbit = 1'b0; e.addr = a;
        s      = byp ? '0 : (p ^ tb_enc(d));
        e.syn  = s;
        if (s != '0) begin
            hit = -1;
            for (int i = 0; i < DW; i++) if (col[i] == s) hit = i;
            if (hit >= 0) begin
                e.data[hit] = ~d[hit];
                e.sbit      = 1'b1;
            end else if ($countones(s) == 1) e.sbit = 1'b1;
            else e.dbit = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [DW-1:0] rnd_data();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[DW-1:0];
    endfunction

    // Output monitor: counters/log model, scoreboard pop, hold-stability check.
    always @(negedge clk) begin
        exp_t e;
        chk("sbit_cnt", sbit_cnt, m_sc);
        chk("dbit_cnt", dbit_cnt, m_dc);
        chk("log_valid", log_valid, m_lv);
        chk("log_dbit", log_dbit, m_ld);
        chk("log_addr", log_addr, m_la);
        chk("log_syndrome", log_syndrome, m_ls);
        if (!rst_n) begin
            chk("in_ready_in_reset", bus.in_ready, 1'b0);
            q.delete();
            m_sc = 0; m_dc = 0; m_lv = 0; m_ld = 0; m_la = '0; m_ls = '0;
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_data", bus.out_data, prev_out.data);
                chk("hold_syndrome", bus.out_syndrome, prev_out.syn);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) chk("spurious_out", bus.out_valid, 1'b0);
                else begin
                    e = q.pop_front();
                    chk("out_data", bus.out_data, e.data);
                    chk("out_sbit", bus.out_sbit_err, e.sbit);
                    chk("out_dbit", bus.out_dbit_err, e.dbit);
                    chk("out_syndrome", bus.out_syndrome, e.syn);
                    if (!clr_stats) begin
                        if (e.sbit && m_sc != 3) m_sc++;
                        if (e.dbit && m_dc != 3) m_dc++;
                        if (((e.sbit || e.dbit) && !m_lv) || (e.dbit && m_lv && !m_ld)) begin
                            m_lv = 1'b1; m_ld = e.dbit; m_la = e.addr; m_ls = e.syn;
                        end
                    end
                end
            end
            if (clr_stats) begin
                m_sc = 0; m_dc = 0; m_lv = 0; m_ld = 0; m_la = '0; m_ls = '0;
            end
            prev_hold     = bus.out_valid && !bus.out_ready;
            prev_out.data = bus.out_data;
            prev_out.syn  = bus.out_syndrome;
        end
    end

    task automatic send(input logic [DW-1:0] d, input logic [PW-1:0] p,
                        input logic [AW-1:0] a, input logic byp);
        bit ok = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = d; bus.in_parity = p;
        bus.in_addr = a; bus.in_bypass = byp; enc_data = d;
        #1 chk("enc_parity", enc_parity, tb_enc(d));
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                q.push_back(model(d, p, a, byp));
                ok = 1'b1;
                break;
            end
            saw_stall = 1'b1;
            @(posedge clk); #1;
        end
        if (!ok) chk("send_timeout", bus.in_ready, 1'b1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (q.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (q.size() != 0) chk("drain_timeout", q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d;
        init_cols();
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_parity = '0;
        bus.in_addr = '0; bus.in_bypass = 1'b0; bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("rst_out_valid", bus.out_valid, 1'b0);
        rst_n = 1'b1;

        // Clean zero beat
        send('0, '0, 10'h001, 1'b0);
        drain();
        chk("clean_sbit_cnt", sbit_cnt, 0);

        // Single data-bit error on bit 0
        send(70'h1, '0, 10'h012, 1'b0);
        drain();
        chk("sb_log_syn", log_syndrome, 8'h83);
        chk("sb_log_addr", log_addr, 10'h012);
        chk("sb_log_dbit", log_dbit, 1'b0);
        chk("sb_cnt", sbit_cnt, 1);

        // Double error (bits 0 and 1) overwrites a correctable log entry
        send(70'h3, '0, 10'h034, 1'b0);
        drain();
        chk("db_log_syn", log_syndrome, 8'h06);
        chk("db_log_addr", log_addr, 10'h034);
        chk("db_log_dbit", log_dbit, 1'b1);
        chk("db_cnt", dbit_cnt, 1);

        // Check-bit error, then the same beat bypassed
        d = rnd_data();
        send(d, tb_enc(d) ^ 8'h01, 10'h055, 1'b0);
        send(d, tb_enc(d) ^ 8'h01, 10'h056, 1'b1);
        drain();
        chk("byp_sbit_cnt", sbit_cnt, 2);
        chk("log_hold_addr", log_addr, 10'h034);

        // Streaming with out_ready pattern 1-0-0-1
        saw_stall = 1'b0;
        stream_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    logic [DW-1:0] sd;
                    logic [PW-1:0] sp;
                    sd = rnd_data();
                    sp = tb_enc(sd);
                    case (i % 4)
                        1: sp = tb_enc(sd ^ (70'h1 << $urandom_range(DW - 1)));
                        2: sp = sp ^ (8'h01 << $urandom_range(PW - 1));
                        3: sp = tb_enc(sd ^ 70'h3 << $urandom_range(DW - 2));
                        default: ;
                    endcase
                    send(sd, sp, AW'(i + 16), 1'b0);
                end
                stream_done = 1'b1;
            end
            begin
                for (int k = 0; k < 400 && !stream_done; k++) begin
                    @(posedge clk); #1;
                    bus.out_ready = (k % 4 == 0) || (k % 4 == 3);
                end
            end
        join
        bus.out_ready = 1'b1;
        drain();
        chk("stream_stall_seen", saw_stall, 1'b1);

        // Clear, then five correctable beats saturate a 2-bit counter
        clr_stats = 1'b1;
        @(posedge clk); #1;
        clr_stats = 1'b0;
        chk("clr_log_valid", log_valid, 1'b0);
        for (int i = 0; i < 5; i++) begin
            d = rnd_data();
            send(d, tb_enc(d ^ (70'h1 << i)), AW'(i + 64), 1'b0);
        end
        drain();
        chk("sat_sbit_cnt", sbit_cnt, 3);

        // clr_stats in the same cycle as an error beat's output handshake
        bus.out_ready = 1'b0;
        d = rnd_data();
        send(d, tb_enc(d) ^ 8'h06, 10'h0aa, 1'b0);
        for (int k = 0; k < 20 && !bus.out_valid; k++) @(negedge clk);
        chk("clr_beat_present", bus.out_valid, 1'b1);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        clr_stats = 1'b1;
        @(posedge clk); #1;
        clr_stats = 1'b0;
        chk("clr_prio_sbit", sbit_cnt, 0);
        chk("clr_prio_dbit", dbit_cnt, 0);
        chk("clr_prio_log", log_valid, 1'b0);

        // Reset with both stages full
        bus.out_ready = 1'b0;
        send(rnd_data(), '0, 10'h101, 1'b0);
        send(rnd_data(), '0, 10'h102, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_out_valid", bus.out_valid, 1'b0);
        chk("rst_mid_in_ready", bus.in_ready, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        d = rnd_data();
        send(d, tb_enc(d), 10'h200, 1'b0);
        drain();
        chk("final_queue_empty", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
